// File: rtl/kf_ppi_pkg.sv
// rtl/kf_ppi_pkg.sv - shared mode encodings, status bit indices and address sizing
package kf_ppi_pkg;

  typedef enum logic [1:0] {
    MODE_BASIC_IN  = 2'b00,
    MODE_BASIC_OUT = 2'b01,
    MODE_STB_IN    = 2'b10,
    MODE_STB_OUT   = 2'b11
  } ppi_mode_e;

  localparam int ST_INTE = 2;
  localparam int ST_BUF  = 3;
  localparam int ST_INTR = 4;
  localparam int ST_OVR  = 5;

  function automatic int addr_width(input int num_ports);
    int w;
    w = $clog2(2 * num_ports);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/kf_ppi_channel.sv
// rtl/kf_ppi_channel.sv - one PPI port: mode, latches, STB/ACK synchronisers, handshake state
module kf_ppi_channel
  import kf_ppi_pkg::*;
#(
  parameter int PW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_data_i,
  input  logic          wr_ctrl_i,
  input  logic          rd_data_i,
  input  logic          rd_status_i,
  input  logic [7:0]    wdata_i,
  input  logic [PW-1:0] pin_i,
  input  logic          stb_ni,
  input  logic          ack_ni,
  output logic [7:0]    data_o,
  output logic [7:0]    status_o,
  output logic [PW-1:0] out_o,
  output logic          io_o,
  output logic          ibf_o,
  output logic          obf_no,
  output logic          intr_o
);

  ppi_mode_e     mode_q, mode_d;
  logic          inte_q, inte_d, ibf_q, ibf_d, obf_n_q, obf_n_d;
  logic          intr_q, intr_d, ovr_q, ovr_d;
  logic [PW-1:0] latch_q, latch_d, out_q, out_d;
  // [0] first sync flop, [1] second, [2] previous synchronised value
  logic [2:0]    stb_sync_q, ack_sync_q;
  logic          stb_fall, stb_rise, ack_fall, ack_rise;

  assign stb_fall = stb_sync_q[2] & ~stb_sync_q[1];
  assign stb_rise = ~stb_sync_q[2] & stb_sync_q[1];
  assign ack_fall = ack_sync_q[2] & ~ack_sync_q[1];
  assign ack_rise = ~ack_sync_q[2] & ack_sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q     <= MODE_BASIC_IN;
      inte_q     <= 1'b0;
      ibf_q      <= 1'b0;
      obf_n_q    <= 1'b1;
      intr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      latch_q    <= '0;
      out_q      <= '0;
      stb_sync_q <= 3'b111;
      ack_sync_q <= 3'b111;
    end else begin
      mode_q     <= mode_d;
      inte_q     <= inte_d;
      ibf_q      <= ibf_d;
      obf_n_q    <= obf_n_d;
      intr_q     <= intr_d;
      ovr_q      <= ovr_d;
      latch_q    <= latch_d;
      out_q      <= out_d;
      stb_sync_q <= {stb_sync_q[1:0], stb_ni};
      ack_sync_q <= {ack_sync_q[1:0], ack_ni};
    end
  end

  always_comb begin
    mode_d  = mode_q;
    inte_d  = inte_q;
    ibf_d   = ibf_q;
    obf_n_d = obf_n_q;
    intr_d  = intr_q;
    ovr_d   = ovr_q;
    latch_d = latch_q;
    out_d   = out_q;
    if (rd_status_i) ovr_d = 1'b0;
    if (wr_ctrl_i) begin
      mode_d  = ppi_mode_e'(wdata_i[1:0]);
      inte_d  = wdata_i[2];
      ibf_d   = 1'b0;
      intr_d  = 1'b0;
      ovr_d   = 1'b0;
      obf_n_d = 1'b1;
    end else begin
      case (mode_q)
        MODE_BASIC_OUT: if (wr_data_i) out_d = wdata_i[PW-1:0];
        MODE_STB_IN: begin
          // a read ending in the same cycle as a strobe frees the latch first
          if (rd_data_i) begin
            ibf_d  = 1'b0;
            intr_d = 1'b0;
          end
          if (stb_fall) begin
            if (!ibf_d) begin
              latch_d = pin_i;
              ibf_d   = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end
          if (stb_rise) intr_d = inte_q & ibf_d;
        end
        MODE_STB_OUT: begin
          if (wr_data_i) begin
            out_d   = wdata_i[PW-1:0];
            obf_n_d = 1'b0;
            intr_d  = 1'b0;
            if (!obf_n_q) ovr_d = 1'b1;
          end else begin
            if (ack_fall) obf_n_d = 1'b1;
            if (ack_rise) intr_d = inte_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    data_o = '0;
    case (mode_q)
      MODE_BASIC_IN: data_o[PW-1:0] = pin_i;
      MODE_STB_IN:   data_o[PW-1:0] = latch_q;
      default:       data_o[PW-1:0] = out_q;
    endcase
  end

  assign intr_o   = intr_q & inte_q;
  assign status_o = {2'b00, ovr_q, intr_o,
                     (mode_q == MODE_STB_OUT) ? ~obf_n_q : ibf_q,
                     inte_q, mode_q};
  assign out_o    = out_q;
  assign io_o     = ~mode_q[0];
  assign ibf_o    = ibf_q;
  assign obf_no   = obf_n_q;

endmodule

// File: rtl/kf_ppi_strobed.sv
// rtl/kf_ppi_strobed.sv - multi-port strobed PPI: bus strobe edges, decode, read mux, irq
module kf_ppi_strobed
  import kf_ppi_pkg::*;
#(
  parameter int  NUM_PORTS  = 2,
  parameter int  PORT_WIDTH = 8,
  localparam int AW         = addr_width(NUM_PORTS)
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            chip_select_n,
  input  logic                            read_enable_n,
  input  logic                            write_enable_n,
  input  logic [AW-1:0]                   address,
  input  logic [7:0]                      data_bus_in,
  output logic [7:0]                      data_bus_out,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] port_in,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] port_out,
  output logic [NUM_PORTS-1:0]            port_io,
  input  logic [NUM_PORTS-1:0]            stb_n,
  input  logic [NUM_PORTS-1:0]            ack_n,
  output logic [NUM_PORTS-1:0]            ibf,
  output logic [NUM_PORTS-1:0]            obf_n,
  output logic [NUM_PORTS-1:0]            intr,
  output logic                            irq
);

  logic          we_q, re_q, wr_end, rd_end, in_range, is_ctrl;
  logic [AW-1:0] idx;
  logic [7:0]    ch_data   [NUM_PORTS];
  logic [7:0]    ch_status [NUM_PORTS];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we_q <= 1'b1;
      re_q <= 1'b1;
    end else begin
      we_q <= write_enable_n;
      re_q <= read_enable_n;
    end
  end

  // strobe end = registered low, live high, still selected
  assign wr_end   = ~we_q & write_enable_n & ~chip_select_n;
  assign rd_end   = ~re_q & read_enable_n & ~chip_select_n;
  assign in_range = (32'(address) < 32'(2 * NUM_PORTS));
  assign idx      = address >> 1;
  assign is_ctrl  = address[0];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ch
    logic sel;
    assign sel = in_range && (idx == AW'(g));

    kf_ppi_channel #(.PW(PORT_WIDTH)) u_ch (
      .clk_i      (clock),
      .rst_ni     (reset_n),
      .wr_data_i  (wr_end & sel & ~is_ctrl),
      .wr_ctrl_i  (wr_end & sel & is_ctrl),
      .rd_data_i  (rd_end & sel & ~is_ctrl),
      .rd_status_i(rd_end & sel & is_ctrl),
      .wdata_i    (data_bus_in),
      .pin_i      (port_in[g*PORT_WIDTH +: PORT_WIDTH]),
      .stb_ni     (stb_n[g]),
      .ack_ni     (ack_n[g]),
      .data_o     (ch_data[g]),
      .status_o   (ch_status[g]),
      .out_o      (port_out[g*PORT_WIDTH +: PORT_WIDTH]),
      .io_o       (port_io[g]),
      .ibf_o      (ibf[g]),
      .obf_no     (obf_n[g]),
      .intr_o     (intr[g])
    );
  end

  always_comb begin
    data_bus_out = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (in_range && (idx == AW'(i))) data_bus_out = is_ctrl ? ch_status[i] : ch_data[i];
    end
  end

  assign irq = |intr;

endmodule

// File: tb/tb_kf_ppi_strobed.sv
// tb/tb_kf_ppi_strobed.sv - self-checking bench for kf_ppi_strobed
module tb_kf_ppi_strobed;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  cs_n = 3'b111;
  logic        re_n = 1'b1, we_n = 1'b1;
  logic [2:0]  addr = 3'd0;
  logic [7:0]  wdata = 8'h00;

  logic [15:0] pin_a = 16'h0;
  logic [1:0]  stb_a = 2'b11, ack_a = 2'b11;
  logic [7:0]  dout_a;
  logic [15:0] pout_a;
  logic [1:0]  io_a, ibf_a, obf_a, intr_a;
  logic        irq_a;

  logic [11:0] pin_b = 12'h0;
  logic [2:0]  stb_b = 3'b111, ack_b = 3'b111;
  logic [7:0]  dout_b;
  logic [11:0] pout_b;
  logic [2:0]  io_b, ibf_b, obf_b, intr_b;
  logic        irq_b;

  logic [7:0]  pin_c = 8'h0;
  logic        stb_c = 1'b1, ack_c = 1'b1;
  logic [7:0]  dout_c, pout_c;
  logic        io_c, ibf_c, obf_c, intr_c, irq_c;

  int n_vec = 0, n_err = 0;

  always #5 clock = ~clock;

  kf_ppi_strobed #(.NUM_PORTS(2), .PORT_WIDTH(8)) dut_a (
    .clock(clock), .reset_n(reset_n), .chip_select_n(cs_n[0]), .read_enable_n(re_n),
    .write_enable_n(we_n), .address(addr[1:0]), .data_bus_in(wdata), .data_bus_out(dout_a),
    .port_in(pin_a), .port_out(pout_a), .port_io(io_a), .stb_n(stb_a), .ack_n(ack_a),
    .ibf(ibf_a), .obf_n(obf_a), .intr(intr_a), .irq(irq_a));

  kf_ppi_strobed #(.NUM_PORTS(3), .PORT_WIDTH(4)) dut_b (
    .clock(clock), .reset_n(reset_n), .chip_select_n(cs_n[1]), .read_enable_n(re_n),
    .write_enable_n(we_n), .address(addr), .data_bus_in(wdata), .data_bus_out(dout_b),
    .port_in(pin_b), .port_out(pout_b), .port_io(io_b), .stb_n(stb_b), .ack_n(ack_b),
    .ibf(ibf_b), .obf_n(obf_b), .intr(intr_b), .irq(irq_b));

  kf_ppi_strobed #(.NUM_PORTS(1), .PORT_WIDTH(8)) dut_c (
    .clock(clock), .reset_n(reset_n), .chip_select_n(cs_n[2]), .read_enable_n(re_n),
    .write_enable_n(we_n), .address(addr[0]), .data_bus_in(wdata), .data_bus_out(dout_c),
    .port_in(pin_c), .port_out(pout_c), .port_io(io_c), .stb_n(stb_c), .ack_n(ack_c),
    .ibf(ibf_c), .obf_n(obf_c), .intr(intr_c), .irq(irq_c));

  // transaction-level model of dut_a
  logic [1:0] m_mode [2];
  bit         m_inte [2], m_ibf [2], m_obf [2], m_intr [2], m_ovr [2];
  logic [7:0] m_latch [2], m_out [2];

  typedef struct {
    bit          wr;
    logic [2:0]  a;
    logic [7:0]  wd;
    logic [15:0] pins;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bus_wr(input int d, input logic [2:0] a, input logic [7:0] v);
    @(negedge clock);
    addr = a; wdata = v; cs_n[d] = 1'b0; we_n = 1'b0;
    @(negedge clock);
    we_n = 1'b1;
    @(negedge clock);
    cs_n[d] = 1'b1;
  endtask

  task automatic bus_rd(input int d, input logic [2:0] a, output logic [7:0] v);
    @(negedge clock);
    addr = a; cs_n[d] = 1'b0; re_n = 1'b0;
    @(negedge clock);
    v = (d == 0) ? dout_a : (d == 1) ? dout_b : dout_c;
    re_n = 1'b1;
    @(negedge clock);
    cs_n[d] = 1'b1;
  endtask

  task automatic pulse_stb(input int p);
    @(negedge clock); stb_a[p] = 1'b0;
    wait_clk(4);      stb_a[p] = 1'b1;
    wait_clk(4);
  endtask

  task automatic pulse_ack(input int p);
    @(negedge clock); ack_a[p] = 1'b0;
    wait_clk(4);      ack_a[p] = 1'b1;
    wait_clk(4);
  endtask

  task automatic check_pins(input string nm);
    logic [1:0]  e_ibf, e_obf_n, e_intr, e_io;
    logic [15:0] e_out;
    for (int p = 0; p < 2; p++) begin
      e_ibf[p]         = m_ibf[p];
      e_obf_n[p]       = ~m_obf[p];
      e_intr[p]        = m_intr[p] & m_inte[p];
      e_io[p]          = (m_mode[p] == 2'd0) || (m_mode[p] == 2'd2);
      e_out[p*8 +: 8]  = m_out[p];
    end
    check(nm, 32'({ibf_a, obf_a, intr_a, io_a, irq_a, pout_a}),
              32'({e_ibf, e_obf_n, e_intr, e_io, |e_intr, e_out}));
  endtask

  initial begin
    logic [7:0] v, e, r;
    int p, op;

    tbl[0]  = '{1'b1, 3'd1, 8'h01, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b1, 3'd0, 8'hA5, 16'h0000, 16'h00A5};
    tbl[2]  = '{1'b0, 3'd0, 8'h00, 16'h0000, 16'h00A5};
    tbl[3]  = '{1'b0, 3'd1, 8'h00, 16'h0000, 16'h0001};
    tbl[4]  = '{1'b1, 3'd3, 8'h00, 16'h0000, 16'h00A5};
    tbl[5]  = '{1'b0, 3'd2, 8'h00, 16'h5A00, 16'h005A};
    tbl[6]  = '{1'b0, 3'd2, 8'h00, 16'hC300, 16'h00C3};
    tbl[7]  = '{1'b1, 3'd2, 8'h77, 16'hC300, 16'h00A5};
    tbl[8]  = '{1'b0, 3'd3, 8'h00, 16'hC300, 16'h0000};
    tbl[9]  = '{1'b1, 3'd1, 8'h04, 16'hC300, 16'h00A5};
    tbl[10] = '{1'b0, 3'd1, 8'h00, 16'hC300, 16'h0004};
    tbl[11] = '{1'b0, 3'd0, 8'h00, 16'h00E7, 16'h00E7};

    wait_clk(2);
    check("reset_a", 32'({pout_a, io_a, ibf_a, obf_a, intr_a, irq_a}), 32'({16'h0, 2'b11, 2'b00, 2'b11, 2'b00, 1'b0}));
    check("reset_c_io", 32'(io_c), 32'(1'b1));
    @(negedge clock); reset_n = 1'b1;
    wait_clk(2);

    for (int i = 0; i < 12; i++) begin
      pin_a = tbl[i].pins;
      if (tbl[i].wr) begin
        bus_wr(0, tbl[i].a, tbl[i].wd);
        check($sformatf("tbl%0d_out", i), 32'(pout_a), 32'(tbl[i].exp));
      end else begin
        bus_rd(0, tbl[i].a, v);
        check($sformatf("tbl%0d_rd", i), 32'(v), 32'(tbl[i].exp[7:0]));
      end
    end

    // strobed input, handshake latency
    bus_wr(0, 3'd1, 8'h06);
    pin_a[7:0] = 8'hA5;
    @(negedge clock); stb_a[0] = 1'b0;
    wait_clk(2);
    check("t2_ibf_before", 32'(ibf_a[0]), 32'(1'b0));
    wait_clk(1);
    check("t2_ibf_3clk", 32'(ibf_a[0]), 32'(1'b1));
    check("t2_intr_low", 32'(intr_a[0]), 32'(1'b0));
    stb_a[0] = 1'b1;
    wait_clk(3);
    check("t2_intr_irq", 32'({intr_a[0], irq_a}), 32'(2'b11));
    bus_rd(0, 3'd0, v);
    check("t2_data", 32'(v), 32'(8'hA5));
    check("t2_cleared", 32'({ibf_a[0], intr_a[0], irq_a}), 32'(3'b000));

    // overrun
    pin_a[7:0] = 8'h11; pulse_stb(0);
    pin_a[7:0] = 8'h22; pulse_stb(0);
    bus_rd(0, 3'd0, v);
    check("t3_data", 32'(v), 32'(8'h11));
    bus_rd(0, 3'd1, v);
    check("t3_status_ovr", 32'(v), 32'(8'h26));
    bus_rd(0, 3'd1, v);
    check("t3_status_clr", 32'(v), 32'(8'h06));

    // strobed output on port 1
    bus_wr(0, 3'd3, 8'h07);
    bus_wr(0, 3'd2, 8'h3C);
    check("t4_out", 32'({pout_a[15:8], obf_a[1], intr_a[1]}), 32'({8'h3C, 1'b0, 1'b0}));
    @(negedge clock); ack_a[1] = 1'b0;
    wait_clk(3);
    check("t4_obf_fall", 32'({obf_a[1], intr_a[1]}), 32'(2'b10));
    ack_a[1] = 1'b1;
    wait_clk(3);
    check("t4_intr_rise", 32'({intr_a[1], irq_a}), 32'(2'b11));
    bus_wr(0, 3'd2, 8'h55);
    check("t4_wr_clr", 32'({pout_a[15:8], obf_a[1], intr_a[1]}), 32'({8'h55, 1'b0, 1'b0}));
    bus_rd(0, 3'd3, v);
    check("t4_status", 32'(v), 32'(8'h0F));

    // read-end coincident with stb_n fall
    pin_a[7:0] = 8'h33; pulse_stb(0);
    pin_a[7:0] = 8'h44;
    @(negedge clock); stb_a[0] = 1'b0; addr = 3'd0; cs_n[0] = 1'b0; re_n = 1'b0;
    @(negedge clock);
    @(negedge clock); v = dout_a; re_n = 1'b1;
    @(negedge clock); cs_n[0] = 1'b1;
    check("t5_rd_old", 32'(v), 32'(8'h33));
    check("t5_ibf", 32'(ibf_a[0]), 32'(1'b1));
    stb_a[0] = 1'b1;
    wait_clk(4);
    bus_rd(0, 3'd1, v);
    check("t5_status", 32'(v), 32'(8'h1E));
    bus_rd(0, 3'd0, v);
    check("t5_new", 32'(v), 32'(8'h44));

    // write-end coincident with ack_n fall
    pulse_ack(1);
    @(negedge clock); ack_a[1] = 1'b0; addr = 3'd2; wdata = 8'h66; cs_n[0] = 1'b0; we_n = 1'b0;
    @(negedge clock);
    @(negedge clock); we_n = 1'b1;
    @(negedge clock); cs_n[0] = 1'b1;
    check("t5_wr_wins", 32'({pout_a[15:8], obf_a[1], intr_a[1]}), 32'({8'h66, 1'b0, 1'b0}));
    ack_a[1] = 1'b1;
    wait_clk(4);
    check("t5_after_rise", 32'({obf_a[1], intr_a[1]}), 32'(2'b01));
    bus_rd(0, 3'd3, v);
    check("t5_out_status", 32'(v), 32'(8'h1F));

    // 3 ports x 4 bits
    bus_rd(1, 3'd6, v);
    check("b_oor6", 32'(v), 32'(8'h00));
    bus_rd(1, 3'd7, v);
    check("b_oor7", 32'(v), 32'(8'h00));
    pin_b = 12'hB00;
    bus_rd(1, 3'd4, v);
    check("b_pins4", 32'(v), 32'(8'h0B));
    bus_wr(1, 3'd7, 8'h01);
    check("b_oor_wr", 32'(io_b), 32'(3'b111));
    bus_wr(1, 3'd1, 8'h01);
    bus_wr(1, 3'd0, 8'hF9);
    check("b_trunc", 32'(pout_b[3:0]), 32'(4'h9));
    bus_rd(1, 3'd0, v);
    check("b_zext", 32'(v), 32'(8'h09));
    bus_wr(1, 3'd3, 8'h06);
    check("b_irq_idle", 32'({intr_b, irq_b}), 32'(4'b0000));
    @(negedge clock); stb_b[1] = 1'b0;
    wait_clk(4); stb_b[1] = 1'b1;
    wait_clk(4);
    check("b_irq_or", 32'({intr_b, irq_b}), 32'(4'b0101));

    // single port
    bus_wr(2, 3'd1, 8'h01);
    bus_wr(2, 3'd0, 8'h81);
    check("c_out", 32'({pout_c, io_c}), 32'({8'h81, 1'b0}));
    bus_rd(2, 3'd1, v);
    check("c_status", 32'(v), 32'(8'h01));

    // randomized traffic on dut_a against the model
    @(negedge clock); reset_n = 1'b0;
    wait_clk(2); reset_n = 1'b1;
    stb_a = 2'b11; ack_a = 2'b11;
    for (int q = 0; q < 2; q++) begin
      m_mode[q] = 2'd0; m_inte[q] = 0; m_ibf[q] = 0; m_obf[q] = 0;
      m_intr[q] = 0; m_ovr[q] = 0; m_latch[q] = 8'h00; m_out[q] = 8'h00;
    end
    wait_clk(2);
    for (int it = 0; it < 160; it++) begin
      p  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 6));
      r  = 8'($urandom);
      case (op)
        0: begin
          bus_wr(0, 3'(2 * p + 1), r);
          m_mode[p] = r[1:0]; m_inte[p] = r[2];
          m_ibf[p] = 0; m_intr[p] = 0; m_ovr[p] = 0; m_obf[p] = 0;
        end
        1: begin
          bus_wr(0, 3'(2 * p), r);
          if (m_mode[p] == 2'd1) m_out[p] = r;
          else if (m_mode[p] == 2'd3) begin
            if (m_obf[p]) m_ovr[p] = 1;
            m_out[p] = r; m_obf[p] = 1; m_intr[p] = 0;
          end
        end
        2: begin
          e = (m_mode[p] == 2'd0) ? pin_a[p*8 +: 8] : (m_mode[p] == 2'd2) ? m_latch[p] : m_out[p];
          bus_rd(0, 3'(2 * p), v);
          check("rnd_data", 32'(v), 32'(e));
          if (m_mode[p] == 2'd2) begin m_ibf[p] = 0; m_intr[p] = 0; end
        end
        3: begin
          e = {2'b00, m_ovr[p], m_intr[p] & m_inte[p],
               (m_mode[p] == 2'd3) ? m_obf[p] : m_ibf[p], m_inte[p], m_mode[p]};
          bus_rd(0, 3'(2 * p + 1), v);
          check("rnd_status", 32'(v), 32'(e));
          m_ovr[p] = 0;
        end
        4: begin
          @(negedge clock); stb_a[p] = 1'b0;
          wait_clk(4);
          if (m_mode[p] == 2'd2) begin
            if (!m_ibf[p]) begin m_latch[p] = pin_a[p*8 +: 8]; m_ibf[p] = 1; end
            else m_ovr[p] = 1;
          end
          stb_a[p] = 1'b1;
          wait_clk(4);
          if (m_mode[p] == 2'd2) m_intr[p] = m_inte[p] & m_ibf[p];
        end
        5: begin
          @(negedge clock); ack_a[p] = 1'b0;
          wait_clk(4);
          if (m_mode[p] == 2'd3) m_obf[p] = 0;
          ack_a[p] = 1'b1;
          wait_clk(4);
          if (m_mode[p] == 2'd3) m_intr[p] = m_inte[p];
        end
        default: pin_a = 16'($urandom);
      endcase
      check_pins("rnd_pins");
    end

    // asynchronous reset while an output buffer is full
    bus_wr(0, 3'd3, 8'h07);
    bus_wr(0, 3'd2, 8'h99);
    check("t1_pre", 32'({obf_a[1], pout_a[15:8]}), 32'({1'b0, 8'h99}));
    @(negedge clock); #2;
    reset_n = 1'b0;
    #1;
    check("t1_async", 32'({obf_a, intr_a, io_a, pout_a}), 32'({2'b11, 2'b00, 2'b11, 16'h0000}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
